// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - run/set sequencing controller for the clock counter chain
// Generates the seconds tick, gates cascade carries and issues set-mode load strobes.
`timescale 1ns/1ps
module time_set_ctrl #(
  parameter int TICK_DIV  = 4,
  parameter int BLINK_DIV = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       carry_sec,
  input  logic       carry_min,
  input  logic [5:0] count_min,
  input  logic [4:0] count_hour,
  output logic       enable_sec,
  output logic       enable_min,
  output logic       enable_hour,
  output logic       clear_sec,
  output logic       load_min,
  output logic [5:0] data_min,
  output logic       load_hour,
  output logic [4:0] data_hour,
  output logic [1:0] set_mode,
  output logic       blink
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    ILLEGAL  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [PW-1:0] presc;
  logic [PW-1:0] blink_presc;
  logic [BW-1:0] blink_cnt;
  logic          in_run;
  logic          inc_evt;
  logic          set_tick;
  logic [5:0]    min_inc;
  logic [4:0]    hour_inc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:      if (btn_mode) state_next = SET_HOUR;
      SET_HOUR: if (btn_mode) state_next = SET_MIN;
      SET_MIN:  if (btn_mode) state_next = RUN;
      default:  state_next = RUN;
    endcase
  end

  // Qualified by reset_n so the enables read 0 while reset is held, whatever the carries do.
  assign in_run      = (state == RUN) && reset_n;
  assign enable_sec  = in_run && (presc == PRESC_LAST);
  assign enable_min  = in_run && carry_sec;
  assign enable_hour = in_run && carry_sec && carry_min;
  assign set_mode    = state;

  assign inc_evt  = btn_inc && !btn_mode;
  assign min_inc  = (count_min  >= 6'd59) ? 6'd0 : count_min  + 6'd1;
  assign hour_inc = (count_hour >= 5'd23) ? 5'd0 : count_hour + 5'd1;
  assign set_tick = (blink_presc == PRESC_LAST);

  // Seconds prescaler only runs while staying in RUN, so every RUN entry restarts at 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
    end else if ((state == RUN) && (state_next == RUN)) begin
      presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
    end else begin
      presc <= '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      blink       <= 1'b0;
      blink_presc <= '0;
      blink_cnt   <= '0;
    end else if (state_next == RUN) begin
      blink       <= 1'b0;
      blink_presc <= '0;
      blink_cnt   <= '0;
    end else if (state_next != state) begin
      blink       <= 1'b1;
      blink_presc <= '0;
      blink_cnt   <= '0;
    end else begin
      blink_presc <= set_tick ? '0 : blink_presc + 1'b1;
      if (set_tick) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          blink     <= ~blink;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      load_hour <= 1'b0;
      data_hour <= '0;
      load_min  <= 1'b0;
      data_min  <= '0;
      clear_sec <= 1'b0;
    end else begin
      load_hour <= (state == SET_HOUR) && inc_evt;
      load_min  <= (state == SET_MIN) && inc_evt;
      clear_sec <= (state == SET_MIN) && btn_mode;
      if ((state == SET_HOUR) && inc_evt) data_hour <= hour_inc;
      if ((state == SET_MIN) && inc_evt)  data_min  <= min_inc;
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - directed plus randomized bench for time_set_ctrl
// Outputs are compared every cycle against a cycle-count based reference model.
`timescale 1ns/1ps
module tb_time_set_ctrl;

  localparam int TD = 4;
  localparam int BD = 2;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       carry_sec = 1'b0;
  logic       carry_min = 1'b0;
  logic [5:0] count_min = '0;
  logic [4:0] count_hour = '0;
  logic       enable_sec, enable_min, enable_hour, clear_sec;
  logic       load_min, load_hour, blink;
  logic [5:0] data_min;
  logic [4:0] data_hour;
  logic [1:0] set_mode;

  int n_vec = 0;
  int n_err = 0;

  int m_mode, m_run_cyc, m_set_cyc;
  int m_clear, m_load_h, m_load_m, m_data_h, m_data_m;

  time_set_ctrl #(.TICK_DIV(TD), .BLINK_DIV(BD)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .btn_mode    (btn_mode),
    .btn_inc     (btn_inc),
    .carry_sec   (carry_sec),
    .carry_min   (carry_min),
    .count_min   (count_min),
    .count_hour  (count_hour),
    .enable_sec  (enable_sec),
    .enable_min  (enable_min),
    .enable_hour (enable_hour),
    .clear_sec   (clear_sec),
    .load_min    (load_min),
    .data_min    (data_min),
    .load_hour   (load_hour),
    .data_hour   (data_hour),
    .set_mode    (set_mode),
    .blink       (blink)
  );

  always #1 clock = ~clock;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_run_cyc = 0; m_set_cyc = 0;
    m_clear = 0; m_load_h = 0; m_load_m = 0; m_data_h = 0; m_data_m = 0;
  endtask

  // One clock edge of the reference model, using the inputs present at that edge.
  task automatic model_edge();
    int bm, bi;
    bm = int'(btn_mode);
    bi = int'(btn_inc);
    m_load_h = (m_mode == 1 && bi == 1 && bm == 0) ? 1 : 0;
    m_load_m = (m_mode == 2 && bi == 1 && bm == 0) ? 1 : 0;
    if (m_load_h == 1) m_data_h = (int'(count_hour) >= 23) ? 0 : int'(count_hour) + 1;
    if (m_load_m == 1) m_data_m = (int'(count_min) >= 59) ? 0 : int'(count_min) + 1;
    m_clear = (m_mode == 2 && bm == 1) ? 1 : 0;
    if (bm == 1) begin
      m_mode = (m_mode + 1) % 3;
      m_run_cyc = 0;
      m_set_cyc = 0;
    end else if (m_mode == 0) begin
      m_run_cyc++;
    end else begin
      m_set_cyc++;
    end
  endtask

  task automatic check_outputs();
    int run, exp_blink;
    run = (m_mode == 0) ? 1 : 0;
    exp_blink = (run == 0 && ((m_set_cyc / (TD * BD)) % 2) == 0) ? 1 : 0;
    check_eq("set_mode", int'(set_mode), m_mode);
    check_eq("enable_sec", int'(enable_sec), (run == 1 && (m_run_cyc % TD) == TD - 1) ? 1 : 0);
    check_eq("enable_min", int'(enable_min), run & int'(carry_sec));
    check_eq("enable_hour", int'(enable_hour), run & int'(carry_sec) & int'(carry_min));
    check_eq("clear_sec", int'(clear_sec), m_clear);
    check_eq("load_hour", int'(load_hour), m_load_h);
    check_eq("data_hour", int'(data_hour), m_data_h);
    check_eq("load_min", int'(load_min), m_load_m);
    check_eq("data_min", int'(data_min), m_data_m);
    check_eq("blink", int'(blink), exp_blink);
  endtask

  task automatic check_zero(input string where);
    check_eq({where, ".set_mode"}, int'(set_mode), 0);
    check_eq({where, ".enable_sec"}, int'(enable_sec), 0);
    check_eq({where, ".enable_min"}, int'(enable_min), 0);
    check_eq({where, ".enable_hour"}, int'(enable_hour), 0);
    check_eq({where, ".clear_sec"}, int'(clear_sec), 0);
    check_eq({where, ".load_hour"}, int'(load_hour), 0);
    check_eq({where, ".data_hour"}, int'(data_hour), 0);
    check_eq({where, ".load_min"}, int'(load_min), 0);
    check_eq({where, ".data_min"}, int'(data_min), 0);
    check_eq({where, ".blink"}, int'(blink), 0);
  endtask

  task automatic step(input logic bm, input logic bi);
    btn_mode = bm;
    btn_inc  = bi;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    check_outputs();
  endtask

  initial begin
    model_reset();
    carry_sec = 1'b1;
    carry_min = 1'b1;
    #5;
    check_zero("in_reset");
    #5;
    reset_n   = 1'b1;
    carry_sec = 1'b0;
    carry_min = 1'b0;
    #0.2;
    check_outputs();

    for (int i = 0; i < 12; i++) step(1'b0, 1'b0);

    carry_sec = 1'b1; carry_min = 1'b0;
    step(1'b0, 1'b0);
    carry_min = 1'b1;
    step(1'b0, 1'b0);
    carry_sec = 1'b0; carry_min = 1'b0;

    step(1'b1, 1'b0);
    count_hour = 5'd23; step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    count_hour = 5'd7;  step(1'b0, 1'b1);
    count_hour = 5'd8;  step(1'b0, 1'b1);
    count_hour = 5'd9;  step(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);

    step(1'b1, 1'b0);
    count_min = 6'd58; step(1'b0, 1'b1);
    count_min = 6'd59; step(1'b0, 1'b1);
    count_min = 6'd62; step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);

    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    count_hour = 5'd3; count_min = 6'd4;
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);

    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    count_min = 6'd10;
    step(1'b0, 1'b1);
    #0.4;
    reset_n = 1'b0;
    #0.3;
    check_zero("async_reset");
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    #0.2;
    check_outputs();
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0);

    for (int i = 0; i < 500; i++) begin
      carry_sec  = 1'($urandom_range(0, 1));
      carry_min  = 1'($urandom_range(0, 1));
      count_min  = 6'($urandom_range(0, 63));
      count_hour = 5'($urandom_range(0, 31));
      step(($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
